embcpu_onchip_mem_bist: RTL and testbench
=========================================

// Module: embcpu_onchip_mem_bist
// PURPOSE
//  Upstream Avalon-MM master for the 32-bit single-port on-chip RAM (1-cycle read latency).
//  Under CPU control via a small CSR slave, it fills the RAM with a seeded pattern or
//  read-checks it against the same pattern. It also counts mismatches and raises an IRQ on completion.
//  A system mux in front of the RAM grants the port to this block while mem_busy=1.
// PARAMETERS
//  ADDR_W   10    RAM word-address width
//  DEPTH    1024  words swept per run (addresses 0..DEPTH-1)
//  DATA_W   32    RAM data width; byteenable width is DATA_W/8
// PORTS
//  clk            in   1       single clock for all logic
//  reset_n        in   1       asynchronous, active-low reset
//  csr_address    in   2       CSR word select
//  csr_read       in   1       CSR read strobe; readdata is valid in the same cycle (0 wait states)
//  csr_write      in   1       CSR write strobe
//  csr_writedata  in   32      CSR write data
//  csr_readdata   out  32      CSR read data
//  irq            out  1       level interrupt = done & irq_en
//  mem_busy       out  1       port-ownership request to the RAM mux
//  mem_address    out  ADDR_W  RAM word address
//  mem_chipselect out  1       RAM chipselect
//  mem_write      out  1       RAM write enable
//  mem_byteenable out  DATA_W/8  all ones while driving; 0 otherwise
//  mem_writedata  out  DATA_W  pattern data
//  mem_clken      out  1       constant 1
//  mem_readdata   in   DATA_W  RAM q, valid the cycle after the address is presented
// BEHAVIOUR
//  CSR map:
//   0 CTRL (RW)
//     b0 start: write-1 pulse, reads 0
//     b1 mode: 0=FILL, 1=CHECK
//     b2 irq_en
//     b3 abort: write-1 pulse
//   1 STATUS
//     b0 busy (RO)
//     b1 done (W1C)
//     b2 fail (W1C)
//     b3 aborted (W1C)
//   2 SEED (RW, 32b)
//   3 RESULT (RO): [31:16] err_count, [15:0] first_fail_addr zero-extended
//  Pattern: expected(a) = SEED + a. a is zero-extended to DATA_W; the sum is modulo 2^DATA_W.
//  FSM states: IDLE, FILL, CHECK, DRAIN.
//  IDLE -> FILL or CHECK on start with busy=0:
//   - clears done, fail, aborted, err_count and first_fail_addr;
//   - sets the address counter to 0.
//   start while busy=1 is ignored; the mode bit still updates and takes effect on the next run.
//  FILL: one write per cycle (cs=1, write=1, data=expected(addr)), addr+1 each cycle.
//   After writing DEPTH-1: -> IDLE, set done.
//  CHECK: one read per cycle (cs=1, write=0), addr+1 each cycle.
//   The expected value is pipelined by one stage and compared with mem_readdata on the next cycle.
//   After issuing DEPTH-1: -> DRAIN.
//  DRAIN: one cycle, no access, performs the final compare; -> IDLE, set done.
//  On mismatch:
//   - err_count increments, saturating at 16'hFFFF;
//   - fail is set;
//   - first_fail_addr is captured only on the first mismatch of the run.
//  abort in FILL/CHECK/DRAIN: -> IDLE next cycle; set done and aborted.
//   Any pending compare is discarded; the address counter is not reset until the next start.
//   abort in IDLE: no effect.
//  start and abort in the same write: abort wins; no run starts.
//  mem_busy=1 from the cycle after start until the cycle the FSM returns to IDLE, inclusive of DRAIN.
//  In IDLE, cs, write and byteenable are 0 and address/writedata hold 0.
//  Address counter is ADDR_W+1 bits wide. Termination compares against DEPTH-1, so no wrap occurs.
//  Reset (async assert, sync deassert is external):
//   - FSM=IDLE; all CSRs, counters, irq and mem_* outputs = 0;
//   - exception: mem_clken = 1.
//   Reset mid-run leaves the RAM partially written; this is not flagged.
//  Run latency: FILL = DEPTH cycles; CHECK = DEPTH+1 cycles (start write to done=1).
// TESTING
//  1. SEED=0x1000_0000, CTRL=0x1 -> 1024 writes, addr 0..1023, data 0x1000_0000..0x1000_03FF;
//     done=1 at cycle 1024; irq=0.
//  2. After test 1, CTRL=0x7 -> 1025 cycles; done=1, fail=0, err_count=0, irq=1 until done is cleared by W1C.
//  3. After test 1, backdoor-corrupt words 5 and 700, then CHECK -> fail=1, RESULT=0x0002_0005.
//  4. CHECK with SEED changed to 0 (mismatches at 1023 addresses) -> err_count=1023, first_fail_addr=0.
//  5. FILL, abort write at cycle 100 -> mem_busy=0 by cycle 102, done=aborted=1;
//     words 0..~99 written, 100+ untouched. Second start while busy -> ignored.
//  6. reset_n low during CHECK -> all outputs 0 immediately (async); irq=0; next start runs normally.

Source files
------------

// File: rtl/embcpu_onchip_mem_bist.sv
// Memory BIST master for a single-port on-chip RAM: fills it with SEED+addr or
// read-checks it against the same pattern, counting mismatches, with an IRQ on completion.
module embcpu_onchip_mem_bist #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          csr_address,
  input  logic                csr_read,
  input  logic                csr_write,
  input  logic [31:0]         csr_writedata,
  output logic [31:0]         csr_readdata,
  output logic                irq,
  output logic                mem_busy,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_CHECK, S_DRAIN} state_t;

  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W:0]   addr;
  logic              mode;
  logic              irq_en;
  logic [31:0]       seed;
  logic              done;
  logic              fail;
  logic              aborted;
  logic [15:0]       err_count;
  logic [ADDR_W-1:0] first_fail_addr;

  // One-deep compare pipeline matching the RAM's single cycle of read latency.
  logic              pend_valid;
  logic [DATA_W-1:0] pend_exp;
  logic [ADDR_W-1:0] pend_addr;

  logic              ctrl_wr;
  logic              status_wr;
  logic              seed_wr;
  logic              start_req;
  logic              abort_req;
  logic              busy;
  logic              at_last;
  logic              run_end;
  logic              mismatch;
  logic [ADDR_W:0]   addr_next;

  function automatic logic [DATA_W-1:0] pattern(input logic [31:0] s, input logic [ADDR_W:0] a);
    return DATA_W'(s) + DATA_W'(a);
  endfunction

  assign ctrl_wr   = csr_write && (csr_address == 2'd0);
  assign status_wr = csr_write && (csr_address == 2'd1);
  assign seed_wr   = csr_write && (csr_address == 2'd2);
  assign abort_req = ctrl_wr && csr_writedata[3];
  assign start_req = ctrl_wr && csr_writedata[0] && !csr_writedata[3];
  assign busy      = (state != S_IDLE);
  assign at_last   = (addr == LAST_ADDR);
  assign addr_next = addr + 1'b1;
  assign run_end   = busy && (abort_req || (state == S_DRAIN) || ((state == S_FILL) && at_last));
  // An abort discards whatever compare is in flight.
  assign mismatch  = pend_valid && !abort_req && (mem_readdata != pend_exp);

  assign irq       = done & irq_en;
  assign mem_clken = 1'b1;

  // NOTE: every branch of a combinational block must assign its outputs; the leading
  // default assignment guarantees that and keeps a latch from being inferred.
  always_comb begin
    csr_readdata = '0;
    if (csr_read) begin
      case (csr_address)
        2'd0: csr_readdata = {28'd0, 1'b0, irq_en, mode, 1'b0};
        2'd1: csr_readdata = {28'd0, aborted, fail, done, busy};
        2'd2: csr_readdata = seed;
        2'd3: csr_readdata = {err_count, 16'(first_fail_addr)};
        default: csr_readdata = '0;
      endcase
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register samples the
  // pre-edge values; later assignments in the block deliberately override earlier ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= S_IDLE;
      addr            <= '0;
      mode            <= 1'b0;
      irq_en          <= 1'b0;
      seed            <= '0;
      done            <= 1'b0;
      fail            <= 1'b0;
      aborted         <= 1'b0;
      err_count       <= '0;
      first_fail_addr <= '0;
      pend_valid      <= 1'b0;
      pend_exp        <= '0;
      pend_addr       <= '0;
      mem_busy        <= 1'b0;
      mem_address     <= '0;
      mem_chipselect  <= 1'b0;
      mem_write       <= 1'b0;
      mem_byteenable  <= '0;
      mem_writedata   <= '0;
    end else begin
      if (ctrl_wr) begin
        mode   <= csr_writedata[1];
        irq_en <= csr_writedata[2];
      end
      if (seed_wr) seed <= csr_writedata;
      if (status_wr) begin
        if (csr_writedata[1]) done    <= 1'b0;
        if (csr_writedata[2]) fail    <= 1'b0;
        if (csr_writedata[3]) aborted <= 1'b0;
      end

      if (mismatch) begin
        fail <= 1'b1;
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        if (err_count == 16'd0)    first_fail_addr <= pend_addr;
      end
      pend_valid <= 1'b0;

      if (run_end) begin
        state          <= S_IDLE;
        done           <= 1'b1;
        if (abort_req) aborted <= 1'b1;
        mem_busy       <= 1'b0;
        mem_address    <= '0;
        mem_chipselect <= 1'b0;
        mem_write      <= 1'b0;
        mem_byteenable <= '0;
        mem_writedata  <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_req) begin
              state           <= csr_writedata[1] ? S_CHECK : S_FILL;
              done            <= 1'b0;
              fail            <= 1'b0;
              aborted         <= 1'b0;
              err_count       <= '0;
              first_fail_addr <= '0;
              addr            <= '0;
              mem_busy        <= 1'b1;
              mem_address     <= '0;
              mem_chipselect  <= 1'b1;
              mem_write       <= !csr_writedata[1];
              mem_byteenable  <= '1;
              mem_writedata   <= csr_writedata[1] ? '0 : pattern(seed, '0);
            end
          end
          S_FILL: begin
            addr          <= addr_next;
            mem_address   <= addr_next[ADDR_W-1:0];
            mem_writedata <= pattern(seed, addr_next);
          end
          S_CHECK: begin
            pend_valid <= 1'b1;
            pend_exp   <= pattern(seed, addr);
            pend_addr  <= addr[ADDR_W-1:0];
            if (at_last) begin
              state          <= S_DRAIN;
              mem_address    <= '0;
              mem_chipselect <= 1'b0;
              mem_byteenable <= '0;
            end else begin
              addr        <= addr_next;
              mem_address <= addr_next[ADDR_W-1:0];
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_embcpu_onchip_mem_bist.sv
// Self-checking bench for embcpu_onchip_mem_bist: behavioural 1-cycle RAM, write-stream
// scoreboard, and one task per scenario.
module tb_embcpu_onchip_mem_bist;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [1:0]        csr_address = '0;
  logic              csr_read = 1'b0;
  logic              csr_write = 1'b0;
  logic [31:0]       csr_writedata = '0;
  logic [31:0]       csr_readdata;
  logic              irq;
  logic              mem_busy;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_write;
  logic [3:0]        mem_byteenable;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;

  always #5 clk = ~clk;

  embcpu_onchip_mem_bist #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .csr_address(csr_address), .csr_read(csr_read), .csr_write(csr_write),
    .csr_writedata(csr_writedata), .csr_readdata(csr_readdata), .irq(irq),
    .mem_busy(mem_busy), .mem_address(mem_address), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
    .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  // Behavioural single-port RAM with one cycle of read latency and a backdoor write port.
  logic [DATA_W-1:0] ram [0:DEPTH-1];
  logic [DATA_W-1:0] ram_q;
  logic              bd_en = 1'b0;
  logic [ADDR_W-1:0] bd_addr = '0;
  logic [DATA_W-1:0] bd_data = '0;

  always @(posedge clk) begin
    if (mem_chipselect && mem_write) ram[mem_address] <= mem_writedata;
    if (mem_chipselect) ram_q <= ram[mem_address];
    if (bd_en) ram[bd_addr] <= bd_data;
  end
  assign mem_readdata = ram_q;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_cmp = 0;
  int  n_err = 0;

  // Scoreboard: every RAM write the DUT issues must match the next expected entry.
  always @(negedge clk) begin
    if (reset_n && mem_chipselect && mem_write) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write", mem_address, mem_writedata);
      end else begin
        mon_e = exp_q.pop_front();
        if ({mem_address, mem_writedata, mem_byteenable} !== {mon_e.a, mon_e.d, 4'hF}) begin
          n_err++;
          $display("FAIL write_stream: got addr=%0d data=%h be=%h, expected addr=%0d data=%h be=f",
                   mem_address, mem_writedata, mem_byteenable, mon_e.a, mon_e.d);
        end
      end
    end
  end

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    csr_address = a; csr_writedata = d; csr_write = 1'b1; csr_read = 1'b0;
    @(posedge clk); #1;
    csr_write = 1'b0; csr_writedata = '0; csr_address = '0;
  endtask

  task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    csr_address = a; csr_read = 1'b1;
    #1 d = csr_readdata;
    csr_read = 1'b0; csr_address = '0;
  endtask

  task automatic backdoor(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    bd_addr = a; bd_data = d; bd_en = 1'b1;
    @(negedge clk);
    bd_en = 1'b0;
  endtask

  task automatic push_fill(input logic [31:0] s, input int n);
    wr_t e;
    for (int i = 0; i < n; i++) begin
      e.a = ADDR_W'(i);
      e.d = s + 32'(i);
      exp_q.push_back(e);
    end
  endtask

  // Counts clock edges after the start write until STATUS.done reads 1.
  task automatic wait_done(input int limit, output int cyc);
    logic seen;
    cyc = 0; seen = 1'b0;
    csr_address = 2'd1; csr_read = 1'b1;
    while (!seen && cyc < limit) begin
      @(posedge clk); #1;
      cyc++;
      seen = csr_readdata[1];
    end
    csr_read = 1'b0; csr_address = '0;
    n_cmp++;
    if (!seen) begin n_err++; $display("FAIL done_timeout: got no done within %0d cycles, expected done", limit); end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    n_cmp++;
    if ({mem_busy, mem_chipselect, mem_write, mem_byteenable, mem_address, mem_writedata, irq, mem_clken} !==
        {1'b0, 1'b0, 1'b0, 4'h0, 10'd0, 32'd0, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL reset_outputs: got busy=%b cs=%b we=%b be=%h addr=%0d wd=%h irq=%b clken=%b, expected all 0 and clken=1",
                        mem_busy, mem_chipselect, mem_write, mem_byteenable, mem_address, mem_writedata, irq, mem_clken);
    end
    for (int r = 0; r < 4; r++) begin
      csr_rd(2'(r), d);
      n_cmp++;
      if (d !== 32'd0) begin n_err++; $display("FAIL reset_csr%0d: got %h expected 00000000", r, d); end
    end
  endtask

  task automatic test_fill();
    logic [31:0] d;
    int cyc;
    csr_wr(2'd2, 32'h1000_0000);
    push_fill(32'h1000_0000, DEPTH);
    csr_wr(2'd0, 32'h1);
    n_cmp++;
    if (mem_busy !== 1'b1) begin n_err++; $display("FAIL fill_busy: got %b expected 1", mem_busy); end
    wait_done(3000, cyc);
    n_cmp++;
    if (cyc != DEPTH) begin n_err++; $display("FAIL fill_latency: got %0d expected %0d", cyc, DEPTH); end
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL fill_missing: got %0d writes outstanding expected 0", exp_q.size()); end
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL fill_irq: got %b expected 0", irq); end
    csr_rd(2'd1, d);
    n_cmp++;
    if (d !== 32'h2) begin n_err++; $display("FAIL fill_status: got %h expected 00000002", d); end
  endtask

  task automatic test_check_pass();
    logic [31:0] d;
    int cyc;
    csr_wr(2'd0, 32'h7);
    n_cmp++;
    if ({mem_busy, mem_chipselect, mem_write} !== 3'b110) begin
      n_err++; $display("FAIL check_first_read: got busy/cs/we=%b expected 110", {mem_busy, mem_chipselect, mem_write});
    end
    wait_done(3000, cyc);
    n_cmp++;
    if (cyc != DEPTH + 1) begin n_err++; $display("FAIL check_latency: got %0d expected %0d", cyc, DEPTH + 1); end
    csr_rd(2'd1, d);
    n_cmp++;
    if (d !== 32'h2) begin n_err++; $display("FAIL check_pass_status: got %h expected 00000002", d); end
    csr_rd(2'd3, d);
    n_cmp++;
    if (d !== 32'h0) begin n_err++; $display("FAIL check_pass_result: got %h expected 00000000", d); end
    n_cmp++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL check_irq_set: got %b expected 1", irq); end
    csr_wr(2'd1, 32'h2);
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL check_irq_clear: got %b expected 0", irq); end
  endtask

  task automatic test_check_corrupt();
    logic [31:0] d;
    int cyc;
    backdoor(10'd5, ~(32'h1000_0005));
    backdoor(10'd700, 32'h0);
    csr_wr(2'd0, 32'h3);
    wait_done(3000, cyc);
    csr_rd(2'd1, d);
    n_cmp++;
    if (d !== 32'h6) begin n_err++; $display("FAIL corrupt_status: got %h expected 00000006", d); end
    csr_rd(2'd3, d);
    n_cmp++;
    if (d !== 32'h0002_0005) begin n_err++; $display("FAIL corrupt_result: got %h expected 00020005", d); end
  endtask

  // SEED=0 makes every word mismatch except 1023, which is rewritten to match.
  task automatic test_check_seed_change();
    logic [31:0] d;
    int cyc;
    backdoor(10'd1023, 32'h3FF);
    csr_wr(2'd2, 32'h0);
    csr_wr(2'd0, 32'h3);
    wait_done(3000, cyc);
    n_cmp++;
    if (cyc != DEPTH + 1) begin n_err++; $display("FAIL seed_latency: got %0d expected %0d", cyc, DEPTH + 1); end
    csr_rd(2'd3, d);
    n_cmp++;
    if (d !== 32'h03FF_0000) begin n_err++; $display("FAIL seed_result: got %h expected 03ff0000", d); end
  endtask

  task automatic test_abort();
    logic [31:0] d;
    csr_wr(2'd2, 32'h5555_0000);
    push_fill(32'h5555_0000, 100);
    csr_wr(2'd0, 32'h1);
    repeat (49) @(posedge clk);
    csr_wr(2'd0, 32'h3);
    csr_rd(2'd0, d);
    n_cmp++;
    if (d !== 32'h2) begin n_err++; $display("FAIL abort_mode_update: got %h expected 00000002", d); end
    repeat (49) @(posedge clk);
    csr_wr(2'd0, 32'h8);
    n_cmp++;
    if ({mem_busy, mem_chipselect} !== 2'b00) begin
      n_err++; $display("FAIL abort_release: got busy/cs=%b expected 00", {mem_busy, mem_chipselect});
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL abort_writes: got %0d outstanding expected 0", exp_q.size()); end
    csr_rd(2'd1, d);
    n_cmp++;
    if (d !== 32'hA) begin n_err++; $display("FAIL abort_status: got %h expected 0000000a", d); end
    n_cmp++;
    if ({ram[99], ram[100]} !== {32'h5555_0063, 32'h1000_0064}) begin
      n_err++; $display("FAIL abort_ram: got w99=%h w100=%h expected 55550063 10000064", ram[99], ram[100]);
    end
    csr_wr(2'd1, 32'hE);
    csr_wr(2'd0, 32'h8);
    csr_rd(2'd1, d);
    n_cmp++;
    if (d !== 32'h0) begin n_err++; $display("FAIL abort_idle: got %h expected 00000000", d); end
    csr_wr(2'd0, 32'h9);
    n_cmp++;
    if (mem_busy !== 1'b0) begin n_err++; $display("FAIL start_abort_same: got busy=%b expected 0", mem_busy); end
    csr_rd(2'd1, d);
    n_cmp++;
    if (d !== 32'h0) begin n_err++; $display("FAIL start_abort_status: got %h expected 00000000", d); end
  endtask

  task automatic test_reset_midrun();
    logic [31:0] d;
    int cyc;
    csr_wr(2'd0, 32'h7);
    repeat (10) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({mem_busy, mem_chipselect, mem_write, mem_byteenable, mem_address, irq, mem_clken} !==
        {1'b0, 1'b0, 1'b0, 4'h0, 10'd0, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL midrun_reset_outputs: got busy=%b cs=%b we=%b be=%h addr=%0d irq=%b clken=%b, expected zeros and clken=1",
                        mem_busy, mem_chipselect, mem_write, mem_byteenable, mem_address, irq, mem_clken);
    end
    csr_rd(2'd0, d);
    n_cmp++;
    if (d !== 32'h0) begin n_err++; $display("FAIL midrun_reset_ctrl: got %h expected 00000000", d); end
    @(negedge clk);
    reset_n = 1'b1;
    csr_wr(2'd2, 32'h2222_0000);
    push_fill(32'h2222_0000, DEPTH);
    csr_wr(2'd0, 32'h1);
    wait_done(3000, cyc);
    n_cmp++;
    if (cyc != DEPTH) begin n_err++; $display("FAIL post_reset_latency: got %0d expected %0d", cyc, DEPTH); end
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL post_reset_writes: got %0d outstanding expected 0", exp_q.size()); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_fill();
    test_check_pass();
    test_check_corrupt();
    test_check_seed_change();
    test_abort();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion by 1000000 time units, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
